// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID pipeline register with two-word instruction assembly (optional IFID_SEQ_CHECK_EN)
module if_id_buffer #(
    parameter int                 PC_W           = 32,
    parameter int                 INSTR_W        = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR      = 16'h0000,
    parameter logic [4:0]         TWO_WORD_MASK  = 5'b11000,
    parameter logic [4:0]         TWO_WORD_MATCH = 5'b11000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               fetch_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_out,
    output logic [INSTR_W-1:0] imm_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               half_pending,
    output logic               seq_err
);

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] hold_word_q, hold_word_d;
    logic [PC_W-1:0]    hold_pc_q, hold_pc_d;

    logic is_two_word;
    assign is_two_word = ((instr_in[INSTR_W-1 -: 5] & TWO_WORD_MASK) == TWO_WORD_MATCH);

    // Next-state and output register values: flush beats stall beats normal fetch handling
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        hold_word_d = hold_word_q;
        hold_pc_d   = hold_pc_q;
        if (flush) begin
            state_d     = S_FIRST;
            instr_d     = NOP_INSTR;
            imm_d       = '0;
            pc_d        = '0;
            valid_d     = 1'b0;
            hold_word_d = '0;
            hold_pc_d   = '0;
        end else if (!stall) begin
            case (state_q)
                S_FIRST: begin
                    if (fetch_valid && !is_two_word) begin
                        instr_d = instr_in;
                        imm_d   = '0;
                        pc_d    = pc_in;
                        valid_d = 1'b1;
                    end else begin
                        // Bubble to decode; pc_out keeps its last value
                        instr_d = NOP_INSTR;
                        imm_d   = '0;
                        valid_d = 1'b0;
                        if (fetch_valid) begin
                            hold_word_d = instr_in;
                            hold_pc_d   = pc_in;
                            state_d     = S_SECOND;
                        end
                    end
                end
                S_SECOND: begin
                    if (fetch_valid) begin
                        // Second word is pure immediate data, never decoded as an opcode
                        instr_d = hold_word_q;
                        imm_d   = instr_in;
                        pc_d    = hold_pc_q;
                        valid_d = 1'b1;
                        state_d = S_FIRST;
                    end
                end
                default: state_d = S_FIRST;
            endcase
        end
    end

    // State updates on the falling edge, in step with the PC register write
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FIRST;
            instr_q     <= NOP_INSTR;
            imm_q       <= '0;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            hold_word_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            hold_word_q <= hold_word_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

`ifdef IFID_SEQ_CHECK_EN
    logic seq_err_q, seq_err_d;
    logic seq_mismatch;
    assign seq_mismatch = (state_q == S_SECOND) && fetch_valid && (pc_in != hold_pc_q + PC_W'(1));

    // Sticky sequence error: only a completing pair can raise it, only reset clears it
    always_comb begin
        seq_err_d = seq_err_q;
        if (!flush && !stall && seq_mismatch) begin
            seq_err_d = 1'b1;
        end
    end

    // Sequence error register, cleared only by reset
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign instr_out    = instr_q;
    assign imm_out      = imm_q;
    assign pc_out       = pc_q;
    assign valid_out    = valid_q;
    assign half_pending = (state_q == S_SECOND);

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - randomized self-checking bench for if_id_buffer against a behavioural model
module tb_if_id_buffer;

`ifdef IFID_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic [15:0] instr_in = '0;
    logic        fetch_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] imm_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        half_pending;
    logic        seq_err;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    if_id_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .fetch_valid  (fetch_valid),
        .stall        (stall),
        .flush        (flush),
        .instr_out    (instr_out),
        .imm_out      (imm_out),
        .pc_out       (pc_out),
        .valid_out    (valid_out),
        .half_pending (half_pending),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a held first half is a queue entry {pc, word}
    logic [15:0] m_instr = '0;
    logic [15:0] m_imm = '0;
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic        m_seq = 1'b0;
    logic [47:0] held[$];

    always @(negedge clk or negedge rst) begin
        logic [47:0] ent;
        if (!rst) begin
            m_instr = 16'h0000; m_imm = '0; m_pc = '0; m_valid = 1'b0; m_seq = 1'b0;
            held.delete();
        end else if (flush) begin
            m_instr = 16'h0000; m_imm = '0; m_pc = '0; m_valid = 1'b0;
            held.delete();
        end else if (!stall) begin
            if (held.size() == 0) begin
                if (!fetch_valid) begin
                    m_instr = 16'h0000; m_imm = '0; m_valid = 1'b0;
                end else if (instr_in >= 16'hC000) begin
                    held.push_back({pc_in, instr_in});
                    m_instr = 16'h0000; m_imm = '0; m_valid = 1'b0;
                end else begin
                    m_instr = instr_in; m_imm = '0; m_pc = pc_in; m_valid = 1'b1;
                end
            end else if (fetch_valid) begin
                ent = held.pop_front();
                m_instr = ent[15:0]; m_imm = instr_in; m_pc = ent[47:16]; m_valid = 1'b1;
                if (SEQ_ON && (pc_in != ent[47:16] + 32'd1)) m_seq = 1'b1;
            end
        end
    end

    // Compare process: outputs change on the falling edge, so check on the rising edge
    always @(posedge clk) begin
        if (chk_en) begin
            check("instr_out", {32'd0, instr_out}, {32'd0, m_instr});
            check("imm_out", {32'd0, imm_out}, {32'd0, m_imm});
            check("pc_out", {16'd0, pc_out}, {16'd0, m_pc});
            check("valid_out", {47'd0, valid_out}, {47'd0, m_valid});
            check("half_pending", {47'd0, half_pending}, {47'd0, (held.size() != 0)});
            check("seq_err", {47'd0, seq_err}, {47'd0, m_seq});
        end
    end

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [15:0] ins,
                         input logic st, input logic fl);
        @(posedge clk);
        #1;
        fetch_valid = fv; pc_in = pc; instr_in = ins; stall = st; flush = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_valid", {47'd0, valid_out}, 48'd0);
        check("rst_instr", {32'd0, instr_out}, 48'd0);
        check("rst_pc", {16'd0, pc_out}, 48'd0);
        check("rst_half", {47'd0, half_pending}, 48'd0);
        check("rst_seq", {47'd0, seq_err}, 48'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        logic [15:0] rins;
        #1;
        check("init_valid", {47'd0, valid_out}, 48'd0);
        check("init_half", {47'd0, half_pending}, 48'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // Single-word fetch
        drive(1, 32'd5, 16'h1234, 0, 0);
        check("sw_instr", {32'd0, instr_out}, 48'h1234);
        check("sw_pc", {16'd0, pc_out}, 48'd5);
        check("sw_valid", {47'd0, valid_out}, 48'd1);
        check("sw_imm", {32'd0, imm_out}, 48'd0);

        // Two-word pair
        drive(1, 32'd8, 16'hC00A, 0, 0);
        check("tw1_valid", {47'd0, valid_out}, 48'd0);
        check("tw1_half", {47'd0, half_pending}, 48'd1);
        drive(1, 32'd9, 16'h00FF, 0, 0);
        check("tw2_instr", {32'd0, instr_out}, 48'hC00A);
        check("tw2_imm", {32'd0, imm_out}, 48'h00FF);
        check("tw2_pc", {16'd0, pc_out}, 48'd8);
        check("tw2_valid", {47'd0, valid_out}, 48'd1);
        check("tw2_half", {47'd0, half_pending}, 48'd0);

        // Stall while a first half is held
        drive(1, 32'd8, 16'hC00A, 0, 0);
        drive(1, 32'd20, 16'h5555, 1, 0);
        check("st1_half", {47'd0, half_pending}, 48'd1);
        check("st1_valid", {47'd0, valid_out}, 48'd0);
        drive(1, 32'd21, 16'h1666, 1, 0);
        check("st2_half", {47'd0, half_pending}, 48'd1);
        check("st2_pc", {16'd0, pc_out}, 48'd8);
        drive(1, 32'd9, 16'h00FF, 0, 0);
        check("st_pair_instr", {32'd0, instr_out}, 48'hC00A);
        check("st_pair_imm", {32'd0, imm_out}, 48'h00FF);

        // Flush mid-pair, with a simultaneous stall
        drive(1, 32'd8, 16'hC00A, 0, 0);
        drive(1, 32'd9, 16'h00FF, 1, 1);
        check("fl_instr", {32'd0, instr_out}, 48'h0000);
        check("fl_valid", {47'd0, valid_out}, 48'd0);
        check("fl_half", {47'd0, half_pending}, 48'd0);
        drive(1, 32'd10, 16'h1111, 0, 0);
        check("fl_next_instr", {32'd0, instr_out}, 48'h1111);
        check("fl_next_valid", {47'd0, valid_out}, 48'd1);
        check("fl_next_pc", {16'd0, pc_out}, 48'd10);

        // Async reset with valid_out high, then mid-pair
        do_reset();
        drive(1, 32'd8, 16'hC00A, 0, 0);
        do_reset();

        // Sequence check: out-of-order pair, then wrap-around pair
        drive(1, 32'd8, 16'hC00A, 0, 0);
        drive(1, 32'd10, 16'h00FF, 0, 0);
        check("seq_bad", {47'd0, seq_err}, {47'd0, SEQ_ON});
        drive(0, 32'd0, 16'h0, 0, 1);
        check("seq_after_flush", {47'd0, seq_err}, {47'd0, SEQ_ON});
        do_reset();
        drive(1, 32'hFFFF_FFFF, 16'hD123, 0, 0);
        drive(1, 32'd0, 16'h0042, 0, 0);
        check("seq_wrap", {47'd0, seq_err}, 48'd0);
        check("wrap_pc", {16'd0, pc_out}, 48'hFFFF_FFFF);
        check("wrap_imm", {32'd0, imm_out}, 48'h0042);

        // Randomized phase: mostly sequential PCs with occasional jumps
        rpc = 32'd100;
        for (int i = 0; i < 500; i++) begin
            rins = 16'($urandom);
            if ($urandom_range(0, 9) < 3) rins[15:14] = 2'b11;
            else if (rins[15:14] == 2'b11) rins[15] = 1'b0;
            if ($urandom_range(0, 19) == 0) rpc = $urandom;
            drive($urandom_range(0, 9) < 7, rpc, rins,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 6);
            if (fetch_valid && !stall) rpc = rpc + 32'd1;
            if (i % 150 == 149) do_reset();
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
